// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver with glitch filtering, odd-parity and framing
//   checks, an inactivity timeout, optional E0/F0 prefix folding and a
//   first-word-fall-through FIFO read port. Fully synchronous to clk.
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 lines
//   rd_valid/rd_ready     FIFO read handshake; rd_data/rd_ext/rd_brk = head entry
//   fifo_count            FIFO occupancy
//   err_parity/frame/timeout  single-cycle error pulses
//   overflow              sticky byte-dropped flag, cleared by clr_overflow
module ps2_rx_fifo #(
    parameter int unsigned CLK_HZ        = 25_000_000,
    parameter int unsigned TIMEOUT_US    = 1000,
    parameter int unsigned FILTER_LEN    = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter bit          DECODE_PREFIX = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic                          rd_ext,
    output logic                          rd_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int unsigned TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned FW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    ck_s_q, dt_s_q;
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall, bit_in;

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [31:0]   to_cnt_q, to_cnt_d;
    logic          done_q, done_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;

    logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic          is_e0, is_f0, push;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, full, wr_en;

    // Filtered level moves only after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_f_d = clk_f_q;
        fcnt_d  = '0;
        if (ck_s_q[1] != clk_f_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) clk_f_d = ck_s_q[1];
            else                               fcnt_d  = fcnt_q + 1'b1;
        end
    end

    assign fall   = clk_f_q & ~clk_f_d;
    assign bit_in = dt_s_q[1];

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        done_d   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        terr_d   = 1'b0;
        to_cnt_d = (state_q == S_IDLE) ? '0 : to_cnt_q + 32'd1;
        if (state_q != S_IDLE && to_cnt_q == 32'(TO_CYCLES - 1)) begin
            terr_d   = 1'b1;
            state_d  = S_IDLE;
            to_cnt_d = '0;
        end else if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!bit_in) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d  = {bit_in, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = bit_in;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!bit_in)                    ferr_d = 1'b1;
                    else if (!(^{shreg_q, par_q})) perr_d = 1'b1;
                    else                            done_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // shreg_q is stable during the done pulse: it only shifts after a new start bit.
    assign is_e0 = DECODE_PREFIX && done_q && (shreg_q == 8'hE0);
    assign is_f0 = DECODE_PREFIX && done_q && (shreg_q == 8'hF0);
    assign push  = done_q && !is_e0 && !is_f0;

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        if (perr_q || ferr_q || terr_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (is_e0) begin
            ext_pend_d = 1'b1;
        end else if (is_f0) begin
            brk_pend_d = 1'b1;
        end else if (push) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop      = rd_valid && rd_ready;
    assign wr_en    = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (push && full && !pop) ovf_d = 1'b1;
        else if (clr_overflow)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ck_s_q     <= '1;
            dt_s_q     <= '1;
            clk_f_q    <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            terr_q     <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ck_s_q     <= {ck_s_q[0], ps2_clk};
            dt_s_q     <= {dt_s_q[0], ps2_data};
            clk_f_q    <= clk_f_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            terr_q     <= terr_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {ext_pend_q, brk_pend_q, shreg_q};
    end

    assign {rd_ext, rd_brk, rd_data} = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;
    assign err_parity  = perr_q;
    assign err_frame   = ferr_q;
    assign err_timeout = terr_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
//   Drives PS/2 frames into a prefix-folding instance and a raw instance and
//   compares popped FIFO entries against a scoreboard of expected entries.
module tb_ps2_rx_fifo;
    localparam int unsigned H = 20;   // clk cycles per PS/2 half period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, reset_raw_n, ps2_clk, ps2_data, rd_ready, clr_overflow;
    logic       rd_valid, rd_ext, rd_brk, err_parity, err_frame, err_timeout, overflow;
    logic [7:0] rd_data;
    logic [3:0] fifo_count;
    logic       raw_valid, raw_ext, raw_brk, raw_perr, raw_ferr, raw_terr, raw_ovf;
    logic [7:0] raw_data;
    logic [3:0] raw_count;

    ps2_rx_fifo #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FILTER_LEN(4),
                  .FIFO_DEPTH(8), .DECODE_PREFIX(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_ext(rd_ext), .rd_brk(rd_brk), .fifo_count(fifo_count),
        .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout),
        .overflow(overflow), .clr_overflow(clr_overflow));

    ps2_rx_fifo #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FILTER_LEN(4),
                  .FIFO_DEPTH(8), .DECODE_PREFIX(1'b0)) dut_raw (
        .clk(clk), .reset_n(reset_raw_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_valid(raw_valid), .rd_ready(1'b1), .rd_data(raw_data),
        .rd_ext(raw_ext), .rd_brk(raw_brk), .fifo_count(raw_count),
        .err_parity(raw_perr), .err_frame(raw_ferr), .err_timeout(raw_terr),
        .overflow(raw_ovf), .clr_overflow(1'b0));

    int n_checks = 0;
    int n_fail   = 0;
    int n_perr = 0, n_ferr = 0, n_terr = 0, n_raw_err = 0;
    logic [9:0] sb_q[$];
    logic [9:0] raw_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err_parity)  n_perr++;
        if (err_frame)   n_ferr++;
        if (err_timeout) n_terr++;
        if (raw_perr || raw_ferr || raw_terr) n_raw_err++;
        if (rd_valid && rd_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_pop", 32'(sb_q.size()), 32'd1);
            else check("sb_entry", 32'({rd_ext, rd_brk, rd_data}), 32'(sb_q.pop_front()));
        end
        if (raw_valid) begin
            if (raw_q.size() == 0) check("raw_unexpected_pop", 32'(raw_q.size()), 32'd1);
            else check("raw_entry", 32'({raw_ext, raw_brk, raw_data}), 32'(raw_q.pop_front()));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic b);
        ps2_data = b;
        cyc(H);
        ps2_clk = 1'b0;
        cyc(H);
        ps2_clk = 1'b1;
    endtask

    // Odd parity: data ones + parity bit must be odd when par_ok is set.
    task automatic send_frame(logic [7:0] b, logic par_ok = 1'b1, logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ ~par_ok);
        send_bit(stop);
        cyc(H);
    endtask

    int p0, f0, t0;

    initial begin
        reset_n = 1'b0; reset_raw_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        rd_ready = 1'b0; clr_overflow = 1'b0;
        cyc(5);
        check("reset_outputs", 32'({rd_valid, rd_ext, rd_brk, rd_data, fifo_count,
                                    err_parity, err_frame, err_timeout, overflow}), 32'd0);
        reset_n = 1'b1;
        cyc(5);

        // Single plain byte, held until rd_ready
        sb_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C);
        check("t1_count", 32'(fifo_count), 32'd1);
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_no_err", 32'(n_perr + n_ferr + n_terr), 32'd0);
        rd_ready = 1'b1;
        cyc(4);
        check("t1_drained", 32'(fifo_count), 32'd0);

        // Prefix folding vs raw instance
        reset_raw_n = 1'b1;
        cyc(2);
        sb_q.push_back({2'b11, 8'h75});
        raw_q.push_back({2'b00, 8'hE0});
        raw_q.push_back({2'b00, 8'hF0});
        raw_q.push_back({2'b00, 8'h75});
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        cyc(5);
        check("t2_raw_done", 32'(raw_q.size()), 32'd0);
        check("t2_raw_count", 32'(raw_count), 32'd0);
        check("t2_raw_clean", 32'({raw_ovf, 4'(n_raw_err)}), 32'd0);
        reset_raw_n = 1'b0;
        sb_q.push_back({2'b10, 8'h5A});
        send_frame(8'hE0); send_frame(8'h5A);
        sb_q.push_back({2'b01, 8'h1C});
        send_frame(8'hF0); send_frame(8'h1C);
        cyc(5);
        check("t2_sb_done", 32'(sb_q.size()), 32'd0);

        // Parity and framing errors
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t3_parity_perr", 32'(n_perr - p0), 32'd1);
        check("t3_parity_ferr", 32'(n_ferr - f0), 32'd0);
        send_frame(8'h1C, 1'b1, 1'b0);
        check("t3_stop_ferr", 32'(n_ferr - f0), 32'd1);
        check("t3_stop_perr", 32'(n_perr - p0), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t3_both_ferr", 32'(n_ferr - f0), 32'd2);
        check("t3_both_perr", 32'(n_perr - p0), 32'd1);
        send_bit(1'b1);
        cyc(H);
        check("t3_idle_ferr", 32'(n_ferr - f0), 32'd3);
        check("t3_no_push", 32'(fifo_count), 32'd0);
        // An error between prefix and byte drops the prefix
        sb_q.push_back({2'b00, 8'h1C});
        send_frame(8'hE0); send_frame(8'h33, 1'b0); send_frame(8'h1C);
        cyc(5);
        check("t3_pend_cleared", 32'(sb_q.size()), 32'd0);

        // Timeout after start + 5 data bits
        t0 = n_terr; f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        cyc(300);
        check("t4_timeout", 32'(n_terr - t0), 32'd1);
        check("t4_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("t4_no_push", 32'(fifo_count), 32'd0);
        sb_q.push_back({2'b00, 8'h29});
        send_frame(8'h29);
        cyc(5);
        check("t4_recovered", 32'(sb_q.size()), 32'd0);

        // Overflow
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb_q.push_back({2'b00, 8'(8'h40 + i)});
            send_frame(8'(8'h40 + i));
        end
        check("t5_full_count", 32'(fifo_count), 32'd8);
        check("t5_overflow", 32'(overflow), 32'd1);
        rd_ready = 1'b1;
        cyc(12);
        check("t5_drained", 32'(fifo_count), 32'd0);
        check("t5_sb_done", 32'(sb_q.size()), 32'd0);
        check("t5_ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        cyc(1);
        clr_overflow = 1'b0;
        check("t5_ovf_cleared", 32'(overflow), 32'd0);

        // Short glitch on ps2_clk must not register as a bit
        f0 = n_ferr;
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(H);
        check("t6_glitch_ferr", 32'(n_ferr - f0), 32'd0);
        sb_q.push_back({2'b00, 8'h33});
        send_frame(8'h33);
        cyc(5);
        check("t6_after_glitch", 32'(sb_q.size()), 32'd0);

        // Reset mid-frame with an entry waiting
        rd_ready = 1'b0;
        send_frame(8'h55);
        check("t6_pre_reset_count", 32'(fifo_count), 32'd1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset_n = 1'b0;
        cyc(2);
        check("t6_reset_outputs", 32'({rd_valid, rd_ext, rd_brk, rd_data, fifo_count,
                                       err_parity, err_frame, err_timeout, overflow}), 32'd0);
        reset_n = 1'b1;
        rd_ready = 1'b1;
        cyc(5);
        sb_q.push_back({2'b00, 8'h66});
        send_frame(8'h66);
        cyc(10);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_raw_clean", 32'(n_raw_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
